// File: rtl/pipe_rf_pkg.sv
// Shared types and default widths for the pipeline register file.
package pipe_rf_pkg;

  localparam int DATA_W_D = 32;
  localparam int ADDR_W_D = 5;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one bit per entry, set on issue, cleared on write-back.
module reg_file_scoreboard
  import pipe_rf_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_D,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           set_i,
  input  logic [ADDR_W-1:0]              set_addr_i,
  input  logic                           clr_i,
  input  logic [ADDR_W-1:0]              clr_addr_i,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr_i,
  output logic [NUM_RD-1:0]              pend_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pend_q, pend_d;

  // Clear first, then set, so a same-cycle issue (younger producer) wins.
  always_comb begin
    pend_d = pend_q;
    if (clr_i) pend_d[clr_addr_i] = 1'b0;
    if (set_i) pend_d[set_addr_i] = 1'b1;
    if (ZERO_REG) pend_d[0] = 1'b0;
  end

  // Pending bits start clean after any reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) pend_q <= '0;
    else          pend_q <= pend_d;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_lkp
    assign pend_o[p] = pend_q[rd_addr_i[p]];
  end

endmodule

// File: rtl/pipe_reg_file.sv
// Parametrised register file: NUM_RD comb read ports, zero reg, write bypass,
// pending-write scoreboard and a post-reset clear sequencer.
module pipe_reg_file
  import pipe_rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_D,
  parameter int ADDR_W   = ADDR_W_D,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic                     wr_en_i,
  input  logic                     wr_dst_sel_i,
  input  logic [ADDR_W-1:0]        wr_rt_i,
  input  logic [ADDR_W-1:0]        wr_rd_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     issue_en_i,
  input  logic [ADDR_W-1:0]        issue_addr_i,
  output logic                     init_done_o
);

  localparam int DEPTH = 1 << ADDR_W;

  rf_state_e         state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] waddr;
  logic              run, wr_ok, issue_ok, mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NUM_RD-1:0] pend;

  assign waddr = wr_dst_sel_i ? wr_rd_i : wr_rt_i;

  // Sequencer state and clear counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Walk every entry once, then hand over to normal operation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + (ADDR_W+1)'(1);
      if (cnt_q == (ADDR_W+1)'(DEPTH-1)) state_d = ST_RUN;
    end
  end

  // Storage port mux: clear writes during INIT, write-back during RUN.
  always_comb begin
    run         = 1'b0;
    init_done_o = 1'b0;
    wr_ok       = 1'b0;
    issue_ok    = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = waddr;
    mem_wdata   = wr_data_i;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q[ADDR_W-1:0];
        mem_wdata = '0;
      end
      ST_RUN: begin
        run         = 1'b1;
        init_done_o = 1'b1;
        wr_ok       = wr_en_i && !(ZERO_REG && waddr == '0);
        issue_ok    = issue_en_i;
        mem_we      = wr_ok;
      end
      default: ;
    endcase
  end

  // Storage array; contents only change through the write port.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  reg_file_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .set_i      (issue_ok),
    .set_addr_i (issue_addr_i),
    .clr_i      (wr_ok),
    .clr_addr_i (waddr),
    .rd_addr_i  (rd_addr_i),
    .pend_o     (pend)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              is_zero, hit;
    assign ra      = rd_addr_i[p*ADDR_W +: ADDR_W];
    assign is_zero = ZERO_REG && ra == '0;
    // wr_ok already excludes the zero register, so a hit never aliases it.
    assign hit     = BYPASS && wr_ok && waddr == ra;
    assign rd_data_o[p*DATA_W +: DATA_W] = (!run || is_zero) ? '0 :
                                           hit ? wr_data_i : mem_q[ra];
    assign rd_busy_o[p] = run && pend[p] && !hit && !is_zero;
  end

endmodule

// File: tb/tb_pipe_reg_file.sv
// Directed bench: default file, a BYPASS=0 twin on the same inputs,
// and a small 4-port 8-entry variant.
module tb_pipe_reg_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared inputs for the 32x32 instances.
  logic [9:0]  rd_addr = '0;
  logic        wr_en = 1'b0, wr_dst_sel = 1'b0, issue_en = 1'b0;
  logic [4:0]  wr_rt = '0, wr_rd = '0, issue_addr = '0;
  logic [31:0] wr_data = '0;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic        done_a, done_b;

  // Small variant inputs.
  logic [11:0] s_rd_addr = '0;
  logic        s_wr_en = 1'b0, s_wr_dst_sel = 1'b0, s_issue_en = 1'b0;
  logic [2:0]  s_wr_rt = '0, s_wr_rd = '0, s_issue_addr = '0;
  logic [31:0] s_wr_data = '0;
  logic [127:0] s_rd_data;
  logic [3:0]  s_rd_busy;
  logic        s_done;

  pipe_reg_file u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a),
    .rd_busy_o(rd_busy_a), .wr_en_i(wr_en), .wr_dst_sel_i(wr_dst_sel),
    .wr_rt_i(wr_rt), .wr_rd_i(wr_rd), .wr_data_i(wr_data),
    .issue_en_i(issue_en), .issue_addr_i(issue_addr), .init_done_o(done_a));

  pipe_reg_file #(.BYPASS(1'b0)) u_nobyp (
    .clk_i(clk), .rst_n_i(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
    .rd_busy_o(rd_busy_b), .wr_en_i(wr_en), .wr_dst_sel_i(wr_dst_sel),
    .wr_rt_i(wr_rt), .wr_rd_i(wr_rd), .wr_data_i(wr_data),
    .issue_en_i(issue_en), .issue_addr_i(issue_addr), .init_done_o(done_b));

  pipe_reg_file #(.ADDR_W(3), .NUM_RD(4)) u_small (
    .clk_i(clk), .rst_n_i(rst_n), .rd_addr_i(s_rd_addr), .rd_data_o(s_rd_data),
    .rd_busy_o(s_rd_busy), .wr_en_i(s_wr_en), .wr_dst_sel_i(s_wr_dst_sel),
    .wr_rt_i(s_wr_rt), .wr_rd_i(s_wr_rd), .wr_data_i(s_wr_data),
    .issue_en_i(s_issue_en), .issue_addr_i(s_issue_addr), .init_done_o(s_done));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; issue_en = 1'b0;
  endtask

  // Release reset and measure cycles until init_done for both sizes.
  task automatic run_init(input string tag, input bit poke);
    int na, ns;
    na = 0; ns = 0;
    rst_n = 1'b1;
    if (poke) begin
      wr_en = 1'b1; wr_dst_sel = 1'b1; wr_rd = 5'd5; wr_data = 32'hFFFF_FFFF;
      issue_en = 1'b1; issue_addr = 5'd5; rd_addr = {5'd5, 5'd5};
    end
    for (int c = 1; c <= 100; c++) begin
      step();
      if (c == 1) begin
        chk({tag, "_init_done_lo"}, 64'(done_a), 64'd0);
        chk({tag, "_init_rd0"}, rd_data_a[63:0], 64'd0);
        chk({tag, "_init_busy"}, 64'(rd_busy_a), 64'd0);
      end
      if (s_done && ns == 0) ns = c;
      if (done_a) begin na = c; break; end
    end
    idle();
    chk({tag, "_init_cycles32"}, 64'(na), 64'd32);
    chk({tag, "_init_cycles8"}, 64'(ns), 64'd8);
    chk({tag, "_nobyp_done"}, 64'(done_b), 64'd1);
  endtask

  initial begin
    // Reset state.
    #2;
    chk("rst_done", {62'd0, done_a, s_done}, 64'd0);
    chk("rst_busy", 64'(rd_busy_a), 64'd0);
    step(); step();

    // 1: clear sequence; writes/issues during INIT are dropped.
    run_init("t1", 1'b1);
    rd_addr = {5'd5, 5'd5};
    #1;
    chk("t1_r5_data", rd_data_a[31:0], 32'd0);
    chk("t1_r5_busy", 64'(rd_busy_a), 64'd0);
    rd_addr = {5'd31, 5'd17};
    #1;
    chk("t1_other_regs", rd_data_a, 64'd0);

    // 2: RegDst selects rd; rt untouched.
    wr_en = 1'b1; wr_dst_sel = 1'b1; wr_rd = 5'd7; wr_rt = 5'd3; wr_data = 32'hDEAD_BEEF;
    rd_addr = {5'd3, 5'd7};
    #1;
    chk("t2_bypass7", rd_data_a[31:0], 32'hDEAD_BEEF);
    chk("t2_nobyp7_old", rd_data_b[31:0], 32'd0);
    step(); idle();
    #1;
    chk("t2_r7", rd_data_a[31:0], 32'hDEAD_BEEF);
    chk("t2_r3_unchanged", rd_data_a[63:32], 32'd0);
    wr_en = 1'b1; wr_dst_sel = 1'b0; wr_rt = 5'd3; wr_rd = 5'd7; wr_data = 32'h0000_00A5;
    step(); idle();
    #1;
    chk("t2_rt_path", rd_data_a, {32'h0000_00A5, 32'hDEAD_BEEF});

    // 3: zero register.
    wr_en = 1'b1; wr_dst_sel = 1'b0; wr_rt = 5'd0; wr_data = 32'h55;
    rd_addr = {5'd0, 5'd0};
    #1;
    chk("t3_r0_same_cycle", rd_data_a[31:0], 32'd0);
    step(); idle();
    issue_en = 1'b1; issue_addr = 5'd0;
    #1;
    chk("t3_r0_after_write", rd_data_a[31:0], 32'd0);
    step(); idle();
    #1;
    chk("t3_r0_busy", 64'(rd_busy_a), 64'd0);

    // 4: same-cycle write forwarding on port 1.
    wr_en = 1'b1; wr_dst_sel = 1'b1; wr_rd = 5'd9; wr_data = 32'h1234;
    rd_addr = {5'd9, 5'd7};
    #1;
    chk("t4_bypass_p1", rd_data_a[63:32], 32'h1234);
    chk("t4_nobyp_old", rd_data_b[63:32], 32'd0);
    step(); idle();
    #1;
    chk("t4_nobyp_after", rd_data_b[63:32], 32'h1234);

    // 5: scoreboard.
    issue_en = 1'b1; issue_addr = 5'd12;
    step(); idle();
    rd_addr = {5'd9, 5'd12};
    #1;
    chk("t5_busy12", 64'(rd_busy_a), 64'b01);
    wr_en = 1'b1; wr_dst_sel = 1'b1; wr_rd = 5'd12; wr_data = 32'hCAFE;
    #1;
    chk("t5_bypass_unbusy", 64'(rd_busy_a), 64'b00);
    chk("t5_nobyp_busy", 64'(rd_busy_b), 64'b01);
    issue_en = 1'b1; issue_addr = 5'd12;
    step(); idle();
    #1;
    chk("t5_set_wins", 64'(rd_busy_a), 64'b01);
    issue_en = 1'b1; issue_addr = 5'd12;
    step(); idle();
    #1;
    chk("t5_reissue", 64'(rd_busy_a), 64'b01);
    wr_en = 1'b1; wr_dst_sel = 1'b1; wr_rd = 5'd12; wr_data = 32'hBEEF;
    step(); idle();
    rd_addr = {5'd12, 5'd12};
    #1;
    chk("t5_cleared", 64'(rd_busy_a), 64'b00);
    chk("t5_dup_ports", rd_data_a, {32'hBEEF, 32'hBEEF});

    // Small variant: 4 ports on one entry, plus a pending bit.
    s_wr_en = 1'b1; s_wr_dst_sel = 1'b0; s_wr_rt = 3'd5; s_wr_data = 32'h77;
    s_issue_en = 1'b1; s_issue_addr = 3'd6;
    step();
    s_wr_en = 1'b0; s_issue_en = 1'b0;
    s_rd_addr = {3'd6, 3'd5, 3'd5, 3'd5};
    #1;
    chk("s_lo3", s_rd_data[95:0], {3{32'h77}});
    chk("s_busy", 64'(s_rd_busy), 64'b1000);

    // 6: mid-run reset.
    issue_en = 1'b1; issue_addr = 5'd20;
    step(); idle();
    rd_addr = {5'd9, 5'd20};
    #1;
    chk("t6_busy20_pre", 64'(rd_busy_a), 64'b01);
    rst_n = 1'b0;
    #1;
    chk("t6_busy_clr", {60'd0, s_rd_busy, rd_busy_a}, 64'd0);
    chk("t6_done_lo", {62'd0, done_a, s_done}, 64'd0);
    step();
    run_init("t6", 1'b0);
    rd_addr = {5'd9, 5'd7};
    s_rd_addr = {3'd6, 3'd5, 3'd5, 3'd5};
    #1;
    chk("t6_r7_r9_zero", rd_data_a, 64'd0);
    chk("t6_r20_busy", 64'(rd_busy_a), 64'd0);
    chk("t6_small_zero", s_rd_data[63:0], 64'd0);
    chk("t6_small_busy", 64'(s_rd_busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
